// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
// Consumes the hazard unit's stall / jump-stop / halt requests for the
// 5-stage MIPS core and turns them into PC and IF/ID write enables plus an
// ID/EX bubble. Registers the jump-stop feedback for the hazard unit and
// sequences the halt drain (EX, MEM, WB) before raising o_end.
//
// Optional feature macro: STALL_STATS_EN
//   When defined, adds o_stall_cycles and o_halt_drain_cycles (32-bit,
//   wrapping) that count enabled cycles spent in STALL and DRAIN.
//   These counters survive i_restart and clear only on reset.

module pipeline_stall_ctrl #(
    parameter int DRAIN_STAGES = 3,
    parameter int MAX_STALL    = 8,
    parameter int CNT_W        = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_enable,
    input  logic        i_stall_req,
    input  logic        i_jmp_req,
    input  logic        i_halt_req,
    input  logic        i_restart,
    output logic        o_pc_wr_en,
    output logic        o_if_id_wr_en,
    output logic        o_id_ex_bubble,
    output logic        o_jmp_stop,
    output logic        o_end,
    output logic        o_stall_err,
`ifdef STALL_STATS_EN
    output logic [31:0] o_stall_cycles,
    output logic [31:0] o_halt_drain_cycles,
`endif
    output logic [1:0]  o_state
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    // Last drain count value before DONE, and the watchdog trip point.
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_STAGES - 1);
    localparam logic [CNT_W-1:0] STALL_TRIP = CNT_W'(MAX_STALL);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] drain_cnt_q;
    logic [CNT_W-1:0] drain_cnt_d;
    logic             advance;
    logic             bubble;
    logic             stall_err_d;

    // Next-state, counter updates and per-cycle pipeline control.
    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        drain_cnt_d = drain_cnt_q;
        advance     = 1'b0;
        bubble      = 1'b0;
        if (i_enable) begin
            unique case (state_q)
                ST_RUN, ST_STALL: begin
                    if (i_halt_req) begin
                        // Halt wins over any stall; the HALT itself is bubbled.
                        state_d     = ST_DRAIN;
                        drain_cnt_d = '0;
                        stall_cnt_d = '0;
                        bubble      = 1'b1;
                    end else if (i_stall_req) begin
                        state_d = ST_STALL;
                        bubble  = 1'b1;
                        if (state_q == ST_RUN) begin
                            stall_cnt_d = CNT_ONE;
                        end else if (stall_cnt_q != STALL_TRIP) begin
                            stall_cnt_d = stall_cnt_q + CNT_ONE;
                        end
                    end else begin
                        // Stall released: advance in this same cycle.
                        state_d     = ST_RUN;
                        stall_cnt_d = '0;
                        advance     = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    bubble      = 1'b1;
                    drain_cnt_d = drain_cnt_q + CNT_ONE;
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    bubble = 1'b1;
                    if (i_restart) begin
                        state_d     = ST_RUN;
                        stall_cnt_d = '0;
                        drain_cnt_d = '0;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // Watchdog is sticky: once the stall run reaches the trip point it stays set.
    assign stall_err_d = o_stall_err | (stall_cnt_d == STALL_TRIP);

    // Enables are forced low while reset is held, regardless of state.
    assign o_pc_wr_en     = advance & i_reset_n;
    assign o_if_id_wr_en  = advance & i_reset_n;
    assign o_id_ex_bubble = bubble & i_reset_n;
    assign o_state        = state_q;

    // State, counters and registered status; frozen whenever i_enable is low.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            drain_cnt_q <= '0;
            o_jmp_stop  <= 1'b0;
            o_end       <= 1'b0;
            o_stall_err <= 1'b0;
        end else if (i_enable) begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            // Jump requests are dropped while the pipeline drains.
            o_jmp_stop  <= (state_q == ST_DRAIN) ? 1'b0 : i_jmp_req;
            o_end       <= (state_d == ST_DONE);
            o_stall_err <= stall_err_d;
        end
    end

`ifdef STALL_STATS_EN
    // Free-running statistics of enabled STALL and DRAIN cycles.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_stall_cycles      <= '0;
            o_halt_drain_cycles <= '0;
        end else if (i_enable) begin
            if (state_q == ST_STALL) begin
                o_stall_cycles <= o_stall_cycles + 32'd1;
            end
            if (state_q == ST_DRAIN) begin
                o_halt_drain_cycles <= o_halt_drain_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Testbench for pipeline_stall_ctrl: directed stimulus, a behavioural model
// checked every falling edge, and hand-computed literal checkpoints.

module tb_pipeline_stall_ctrl;

    localparam int DRAIN_N = 3;
    localparam int MAX_N   = 8;

    localparam int M_RUN   = 0;
    localparam int M_STALL = 1;
    localparam int M_DRAIN = 2;
    localparam int M_DONE  = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic en, stall, jmp, halt, restart;
    logic pc_en, ifid_en, bub, jstop, done, err;
    logic [1:0] st;
`ifdef STALL_STATS_EN
    logic [31:0] st_cyc, dr_cyc;
`endif

    int total = 0;
    int bad   = 0;

    // model state
    int m_mode, m_run, m_drained;
    bit m_jmp, m_end, m_err;
    longint m_stall_cyc, m_drain_cyc;

    pipeline_stall_ctrl #(.DRAIN_STAGES(DRAIN_N), .MAX_STALL(MAX_N), .CNT_W(4)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_stall_req(stall),
        .i_jmp_req(jmp), .i_halt_req(halt), .i_restart(restart),
        .o_pc_wr_en(pc_en), .o_if_id_wr_en(ifid_en), .o_id_ex_bubble(bub),
        .o_jmp_stop(jstop), .o_end(done), .o_stall_err(err),
`ifdef STALL_STATS_EN
        .o_stall_cycles(st_cyc), .o_halt_drain_cycles(dr_cyc),
`endif
        .o_state(st)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", nm, $time, got, exp);
        end
    endtask

    // Behavioural model: pipeline mode plus counts of consecutive stalled
    // cycles and completed drain cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = M_RUN; m_run = 0; m_drained = 0;
            m_jmp = 0; m_end = 0; m_err = 0;
            m_stall_cyc = 0; m_drain_cyc = 0;
        end else if (en) begin
            m_jmp = (m_mode == M_DRAIN) ? 1'b0 : jmp;
            if (m_mode == M_STALL) m_stall_cyc = (m_stall_cyc + 1) % 64'h1_0000_0000;
            if (m_mode == M_DRAIN) m_drain_cyc = (m_drain_cyc + 1) % 64'h1_0000_0000;
            case (m_mode)
                M_RUN, M_STALL: begin
                    if (halt) begin
                        m_mode = M_DRAIN; m_drained = 0; m_run = 0;
                    end else if (stall) begin
                        m_mode = M_STALL;
                        m_run = (m_run + 1 > MAX_N) ? MAX_N : m_run + 1;
                    end else begin
                        m_mode = M_RUN; m_run = 0;
                    end
                end
                M_DRAIN: begin
                    m_drained++;
                    if (m_drained == DRAIN_N) m_mode = M_DONE;
                end
                default: if (restart) begin
                    m_mode = M_RUN; m_drained = 0; m_run = 0;
                end
            endcase
            if (m_run >= MAX_N) m_err = 1;
            m_end = (m_mode == M_DONE);
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        bit advance;
        advance = rst_n && en && (m_mode == M_RUN || m_mode == M_STALL) && !halt && !stall;
        chk("pc_wr_en",    32'(pc_en),   32'(advance));
        chk("if_id_wr_en", 32'(ifid_en), 32'(advance));
        chk("bubble",      32'(bub),     32'(rst_n && en && !advance));
        chk("jmp_stop",    32'(jstop),   32'(m_jmp));
        chk("end",         32'(done),    32'(m_end));
        chk("stall_err",   32'(err),     32'(m_err));
        chk("state",       32'(st),      32'(m_mode));
`ifdef STALL_STATS_EN
        chk("stall_cycles", st_cyc, 32'(m_stall_cyc));
        chk("drain_cycles", dr_cyc, 32'(m_drain_cyc));
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0; en = 0; stall = 0; jmp = 0; halt = 0; restart = 0;
        repeat (2) step();
        chk("rst_state", 32'(st), 0);
        chk("rst_pc", 32'(pc_en), 0);
        chk("rst_end", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_jmp", 32'(jstop), 0);
        rst_n = 1; en = 1;
        repeat (5) step();
        chk("idle_pc", 32'(pc_en), 1);
        chk("idle_ifid", 32'(ifid_en), 1);
        chk("idle_bub", 32'(bub), 0);
        chk("idle_state", 32'(st), 0);

        // two-cycle stall
        stall = 1; #1;
        chk("stall1_pc", 32'(pc_en), 0);
        chk("stall1_bub", 32'(bub), 1);
        step();
        chk("stall_state", 32'(st), 1);
        chk("stall2_pc", 32'(pc_en), 0);
        step();
        stall = 0; #1;
        chk("unstall_pc", 32'(pc_en), 1);
        step();
        chk("unstall_state", 32'(st), 0);
        chk("unstall_err", 32'(err), 0);

        // jump-stop feedback
        jmp = 1; step(); jmp = 0;
        chk("jmp_n1", 32'(jstop), 1);
        step();
        chk("jmp_clr", 32'(jstop), 0);
        jmp = 1; repeat (3) step(); jmp = 0;
        chk("jmp_n3", 32'(jstop), 1);
        step();
        chk("jmp_n4", 32'(jstop), 0);

        // simultaneous halt + stall, drain, restart
        halt = 1; stall = 1; #1;
        chk("halt_pc", 32'(pc_en), 0);
        chk("halt_bub", 32'(bub), 1);
        step(); halt = 0; stall = 0;
        chk("drain_state", 32'(st), 2);
        jmp = 1;
        step();
        chk("drain_end1", 32'(done), 0);
        chk("drain_jmp", 32'(jstop), 0);
        jmp = 0;
        step();
        chk("drain_end2", 32'(done), 0);
        step();
        chk("drain_end3", 32'(done), 1);
        chk("done_state", 32'(st), 3);
        step();
        chk("done_hold", 32'(done), 1);
        restart = 1; step(); restart = 0;
        chk("restart_state", 32'(st), 0);
        chk("restart_end", 32'(done), 0);
        chk("restart_pc", 32'(pc_en), 1);

        // watchdog
        stall = 1;
        repeat (7) step();
        chk("wd_7", 32'(err), 0);
        step();
        chk("wd_8", 32'(err), 1);
        stall = 0; step();
        chk("wd_run", 32'(st), 0);
        chk("wd_sticky", 32'(err), 1);
        step();
        rst_n = 0; #1;
        chk("wd_reset", 32'(err), 0);
        step(); rst_n = 1;
        step();

        // halt from STALL
        stall = 1; step();
        halt = 1; step(); halt = 0; stall = 0;
        chk("stall_halt_state", 32'(st), 2);
        repeat (3) step();
        chk("stall_halt_end", 32'(done), 1);
        restart = 1; step(); restart = 0;

        // enable freeze mid-drain
        halt = 1; step(); halt = 0;
        step();
        en = 0;
        repeat (4) step();
        chk("frz_state", 32'(st), 2);
        chk("frz_end", 32'(done), 0);
        chk("frz_pc", 32'(pc_en), 0);
        chk("frz_bub", 32'(bub), 0);
        en = 1;
        step();
        chk("frz_end_late", 32'(done), 0);
        step();
        chk("frz_end_now", 32'(done), 1);
        restart = 1; step(); restart = 0;

        // async reset mid-drain
        halt = 1; step(); halt = 0;
        step();
        #2 rst_n = 0; #1;
        chk("async_state", 32'(st), 0);
        chk("async_bub", 32'(bub), 0);
        step(); rst_n = 1;
        step();

        // async reset in DONE
        halt = 1; step(); halt = 0;
        repeat (3) step();
        chk("done2_end", 32'(done), 1);
        #2 rst_n = 0; #1;
        chk("done2_async_end", 32'(done), 0);
        chk("done2_async_state", 32'(st), 0);
        step(); rst_n = 1;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
